// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: PC register, pipelined imem reads, PC/instruction queue to decode.
// Define IFQ_BYPASS_EN to forward an accepted response straight to decode when the queue is empty.
module inst_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        pc_sel_i,
   input  logic [31:0] pc_target_i,
   output logic [31:0] inst_o,
   output logic [31:0] pc_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i
);
   localparam int          AW      = $clog2(DEPTH);
   localparam int          CW      = AW + 1;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pend_mem_q [DEPTH];
   logic [31:0]   pend_mem_d [DEPTH];
   logic [AW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [31:0]   q_inst_q [DEPTH];
   logic [31:0]   q_inst_d [DEPTH];
   logic [31:0]   q_pc_q [DEPTH];
   logic [31:0]   q_pc_d [DEPTH];
   logic [AW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   last_pc_q, last_pc_d;

   logic          grant, accept, bypass, q_push, q_pop, q_empty;
   logic [31:0]   rsp_pc;

   always_comb begin
      q_empty     = (count_q == '0);
      // Credit: in-flight plus buffered never exceeds the queue size.
      imem_req_o  = ~rst_i & ~pc_sel_i & (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C);
      imem_addr_o = fetch_pc_q;
      grant       = imem_req_o & imem_gnt_i;
      rsp_pc      = pend_mem_q[pend_rd_q];
      accept      = imem_rvalid_i & (discard_q == '0) & ~pc_sel_i;
`ifdef IFQ_BYPASS_EN
      bypass      = accept & q_empty;
`else
      bypass      = 1'b0;
`endif
      q_pop        = ~q_empty & inst_ready_i;
      q_push       = accept & ~(bypass & inst_ready_i);
      inst_valid_o = ~q_empty | bypass;
      if (!q_empty) begin
         inst_o = q_inst_q[q_rd_q];
         pc_o   = q_pc_q[q_rd_q];
      end else if (bypass) begin
         inst_o = imem_rdata_i;
         pc_o   = rsp_pc;
      end else begin
         inst_o = NOP;
         pc_o   = last_pc_q;
      end

      fetch_pc_d = fetch_pc_q;
      pend_mem_d = pend_mem_q;
      pend_wr_d  = pend_wr_q;
      pend_rd_d  = pend_rd_q;
      discard_d  = discard_q;
      q_inst_d   = q_inst_q;
      q_pc_d     = q_pc_q;
      q_wr_d     = q_wr_q;
      q_rd_d     = q_rd_q;
      last_pc_d  = pc_o;

      if (grant) begin
         pend_mem_d[pend_wr_q] = fetch_pc_q;
         pend_wr_d             = pend_wr_q + AW'(1);
         fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (imem_rvalid_i) begin
         pend_rd_d = pend_rd_q + AW'(1);
         if (discard_q != '0) discard_d = discard_q - CW'(1);
      end
      inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);

      if (q_push) begin
         q_inst_d[q_wr_q] = imem_rdata_i;
         q_pc_d[q_wr_q]   = rsp_pc;
         q_wr_d           = q_wr_q + AW'(1);
      end
      if (q_pop) q_rd_d = q_rd_q + AW'(1);
      count_d = count_q + CW'(q_push) - CW'(q_pop);

      // Redirect: every fetch still outstanding (minus one returning now) is stale.
      if (pc_sel_i) begin
         fetch_pc_d = pc_target_i & 32'hFFFF_FFFC;
         discard_d  = inflight_q - CW'(imem_rvalid_i);
         q_wr_d     = '0;
         q_rd_d     = '0;
         count_d    = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q <= RESET_PC;
         pend_wr_q  <= '0;
         pend_rd_q  <= '0;
         inflight_q <= '0;
         discard_q  <= '0;
         q_wr_q     <= '0;
         q_rd_q     <= '0;
         count_q    <= '0;
         last_pc_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pend_mem_q[i] <= '0;
            q_inst_q[i]   <= '0;
            q_pc_q[i]     <= '0;
         end
      end else begin
         fetch_pc_q <= fetch_pc_d;
         pend_mem_q <= pend_mem_d;
         pend_wr_q  <= pend_wr_d;
         pend_rd_q  <= pend_rd_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
         q_inst_q   <= q_inst_d;
         q_pc_q     <= q_pc_d;
         q_wr_q     <= q_wr_d;
         q_rd_q     <= q_rd_d;
         count_q    <= count_d;
         last_pc_q  <= last_pc_d;
      end
   end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: instruction-memory model plus queue-level reference model.
module tb_inst_fetch_queue;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_gnt, imem_rvalid, pc_sel, inst_valid, inst_ready;
   logic [31:0] imem_addr, imem_rdata, pc_target, inst, pc;
   logic        w_req, w_valid;
   logic [31:0] w_addr, w_inst, w_pc;

   inst_fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_i(rst), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
      .imem_gnt_i(imem_gnt), .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
      .pc_sel_i(pc_sel), .pc_target_i(pc_target), .inst_o(inst), .pc_o(pc),
      .inst_valid_o(inst_valid), .inst_ready_i(inst_ready));

   inst_fetch_queue #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_w (
      .clk_i(clk), .rst_i(rst), .imem_req_o(w_req), .imem_addr_o(w_addr),
      .imem_gnt_i(1'b1), .imem_rvalid_i(1'b0), .imem_rdata_i(32'h0),
      .pc_sel_i(1'b0), .pc_target_i(32'h0), .inst_o(w_inst), .pc_o(w_pc),
      .inst_valid_o(w_valid), .inst_ready_i(1'b0));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] m_fetch_pc, m_last_pc, stream_pc;
   logic [31:0] m_pend[$];
   int          m_pend_cyc[$];
   logic [31:0] mq_pc[$];
   logic [31:0] mq_inst[$];
   int          m_disc;
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_inst, s_pc;

   function automatic logic [31:0] imem(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      return (a * 32'h9E37_79B1) ^ 32'hA5A5_0013;
   endfunction

   function automatic void model_reset();
      m_fetch_pc = 32'h0;
      m_last_pc  = 32'h0;
      stream_pc  = 32'h0;
      m_pend.delete();
      m_pend_cyc.delete();
      mq_pc.delete();
      mq_inst.delete();
      m_disc = 0;
   endfunction

   // One clock: drive inputs, compare every output with the model, advance the model.
   task automatic step(input bit gnt, input bit rv, input bit rdy, input bit sel,
                       input logic [31:0] tgt);
      bit          rvalid, exp_req, accept, byp, hs;
      logic [31:0] e_inst, e_pc, rpc;
      @(negedge clk);
      rvalid      = rv && (m_pend.size() > 0) && (m_pend_cyc[0] < cyc);
      rst         = 1'b0;
      imem_gnt    = gnt;
      imem_rvalid = rvalid;
      imem_rdata  = rvalid ? imem(m_pend[0]) : $urandom;
      pc_sel      = sel;
      pc_target   = tgt;
      inst_ready  = rdy;
      #1;
      exp_req = !sel && ((m_pend.size() + mq_pc.size()) < DEPTH);
      accept  = rvalid && (m_disc == 0) && !sel;
      byp     = BYP && accept && (mq_pc.size() == 0);
      if (mq_pc.size() > 0) begin
         e_inst = mq_inst[0]; e_pc = mq_pc[0];
      end else if (byp) begin
         e_inst = imem(m_pend[0]); e_pc = m_pend[0];
      end else begin
         e_inst = NOP; e_pc = m_last_pc;
      end
      checks += 5;
      if (imem_req !== exp_req) begin
         errors++; $display("FAIL req cyc %0d: got %b expected %b", cyc, imem_req, exp_req);
      end
      if (imem_addr !== m_fetch_pc) begin
         errors++; $display("FAIL addr cyc %0d: got %h expected %h", cyc, imem_addr, m_fetch_pc);
      end
      if (inst_valid !== ((mq_pc.size() > 0) || byp)) begin
         errors++; $display("FAIL valid cyc %0d: got %b expected %b", cyc, inst_valid, (mq_pc.size() > 0) || byp);
      end
      if (inst !== e_inst) begin
         errors++; $display("FAIL inst cyc %0d: got %h expected %h", cyc, inst, e_inst);
      end
      if (pc !== e_pc) begin
         errors++; $display("FAIL pc cyc %0d: got %h expected %h", cyc, pc, e_pc);
      end
      s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_inst = inst; s_pc = pc;
      hs = ((mq_pc.size() > 0) || byp) && rdy && !sel;
      if (hs) begin
         checks++;
         if (pc !== stream_pc || inst !== imem(stream_pc)) begin
            errors++;
            $display("FAIL stream cyc %0d: got pc %h inst %h expected pc %h inst %h",
                     cyc, pc, inst, stream_pc, imem(stream_pc));
         end
         stream_pc = stream_pc + 32'd4;
      end
      if (sel) begin
         if (rvalid) begin
            void'(m_pend.pop_front()); void'(m_pend_cyc.pop_front());
         end
         m_disc = m_pend.size();
         mq_pc.delete(); mq_inst.delete();
         m_fetch_pc = tgt & 32'hFFFF_FFFC;
         stream_pc  = m_fetch_pc;
      end else begin
         if (mq_pc.size() > 0 && rdy) begin
            void'(mq_pc.pop_front()); void'(mq_inst.pop_front());
         end
         if (rvalid) begin
            rpc = m_pend.pop_front(); void'(m_pend_cyc.pop_front());
            if (m_disc > 0) m_disc--;
            else if (!(byp && rdy)) begin
               mq_pc.push_back(rpc); mq_inst.push_back(imem(rpc));
            end
         end
         if (exp_req && gnt) begin
            m_pend.push_back(m_fetch_pc); m_pend_cyc.push_back(cyc);
            m_fetch_pc = m_fetch_pc + 32'd4;
         end
      end
      m_last_pc = e_pc;
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      pc_sel = 1'b0; pc_target = 32'h0; inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (imem_req !== 1'b0 || imem_addr !== 32'h0 || inst_valid !== 1'b0 ||
          inst !== NOP || pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_values: got req %b addr %h valid %b inst %h pc %h expected 0 0 0 %h 0",
                  imem_req, imem_addr, inst_valid, inst, pc, NOP);
      end
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      step(1, 0, 1, 0, 32'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h0) begin
         errors++; $display("FAIL first_req: got req %b addr %h expected 1 00000000", s_req, s_addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 1, 0, 32'h0);
         if (i < 4) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'(4 * i)) begin
               errors++; $display("FAIL stream_addr %0d: got req %b addr %h expected 1 %h", i, s_req, s_addr, 32'(4 * i));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int grants = 0;
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1, 1, 0, 0, 32'h0);
         if (s_req) grants++;
      end
      checks++;
      if (grants != DEPTH || s_req !== 1'b0) begin
         errors++; $display("FAIL credit_stop: got grants %0d req %b expected %0d 0", grants, s_req, DEPTH);
      end
      step(1, 1, 1, 0, 32'h0);
      step(1, 1, 0, 0, 32'h0);
      checks++;
      if (s_req !== 1'b1 || s_addr !== 32'h10) begin
         errors++; $display("FAIL credit_resume: got req %b addr %h expected 1 00000010", s_req, s_addr);
      end
   endtask

   task automatic test_redirect();
      bit found = 0;
      do_reset();
      step(1, 0, 1, 0, 32'h0);
      step(1, 1, 1, 0, 32'h0);
      step(1, 1, 1, 0, 32'h0);
      step(1, 0, 1, 0, 32'h0);
      step(1, 0, 1, 1, 32'h103);
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 1, 0, 32'h0);
         if (i == 0) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h100) begin
               errors++; $display("FAIL redirect_addr: got req %b addr %h expected 1 00000100", s_req, s_addr);
            end
         end
         if (s_valid && !found) begin
            found = 1;
            checks++;
            if (s_pc !== 32'h100) begin
               errors++; $display("FAIL redirect_first_pc: got %h expected 00000100", s_pc);
            end
         end
      end
      if (!found) begin
         checks++; errors++; $display("FAIL redirect_timeout: got no valid expected valid within 20 cycles");
      end
   endtask

   task automatic test_redirect_rvalid();
      do_reset();
      repeat (4) step(1, 0, 0, 0, 32'h0);
      step(0, 1, 0, 0, 32'h0);
      step(0, 1, 1, 1, 32'h40);
      step(0, 0, 1, 0, 32'h0);
      checks++;
      if (s_valid !== 1'b0) begin
         errors++; $display("FAIL flush_empty: got valid %b expected 0", s_valid);
      end
      repeat (15) step(1, 1, 1, 0, 32'h0);
   endtask

   task automatic test_wrap();
      logic [31:0] e;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0, 32'h0);
         e = WRAP_PC + 32'(4 * i);
         checks++;
         if (w_req !== 1'b1 || w_addr !== e) begin
            errors++; $display("FAIL wrap_addr %0d: got req %b addr %h expected 1 %h", i, w_req, w_addr, e);
         end
      end
      step(0, 0, 0, 0, 32'h0);
      checks++;
      if (w_req !== 1'b0 || w_valid !== 1'b0 || w_inst !== NOP || w_pc !== 32'h0) begin
         errors++; $display("FAIL wrap_stop: got req %b valid %b inst %h pc %h expected 0 0 %h 0",
                            w_req, w_valid, w_inst, w_pc, NOP);
      end
   endtask

   task automatic test_bypass();
      do_reset();
      step(1, 0, 1, 0, 32'h0);
      step(0, 1, 1, 0, 32'h0);
      checks++;
      if (s_valid !== BYP || (BYP && s_inst !== 32'h0050_0093)) begin
         errors++; $display("FAIL bypass_same_cycle: got valid %b inst %h expected %b 00500093", s_valid, s_inst, BYP);
      end
      step(0, 0, 0, 0, 32'h0);
      checks++;
      if (s_valid !== !BYP) begin
         errors++; $display("FAIL bypass_next_cycle: got valid %b expected %b", s_valid, !BYP);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) do_reset();
         step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4, $urandom);
      end
   endtask

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
      pc_sel = 1'b0; pc_target = 32'h0; inst_ready = 1'b0;
      model_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_rvalid();
      test_wrap();
      test_bypass();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
